// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store unit: mem_op encodings,
// controller state codes, byte-enable patterns and the latched-op record.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    localparam logic [1:0] LSU_IDLE = 2'd0;
    localparam logic [1:0] LSU_REQ  = 2'd1;
    localparam logic [1:0] LSU_RESP = 2'd2;
    localparam logic [1:0] LSU_DONE = 2'd3;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    // Access attributes kept for the whole transaction (response steering).
    typedef struct packed {
        logic       store;
        logic [2:0] op;
        logic [1:0] off;
    } lsu_op_t;

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/grant/response port between the LSU and data memory.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
);

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [BE_W-1:0]   dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication and legality for
// the incoming access, plus lane extraction and extension of returned data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        st_op,
    input  logic [1:0]        st_off,
    input  logic              st_store,
    input  logic [DATA_W-1:0] st_wdata,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata_rep,
    output logic              legal,
    input  logic [2:0]        ld_op,
    input  logic [1:0]        ld_off,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_ext
);

    logic        sext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Enables and replicated data depend only on access size and offset.
    always_comb begin
        be        = BE_WORD;
        wdata_rep = st_wdata;
        case (st_op[1:0])
            2'b00: begin
                be        = BE_BYTE << st_off;
                wdata_rep = {4{st_wdata[7:0]}};
            end
            2'b01: begin
                be        = BE_HALF << {st_off[1], 1'b0};
                wdata_rep = {2{st_wdata[15:0]}};
            end
            default: begin
                be        = BE_WORD;
                wdata_rep = st_wdata;
            end
        endcase
    end

    // Unsigned variants exist for loads only.
    always_comb begin
        legal = 1'b1;
        case (st_op)
            MEM_B, MEM_BU: legal = 1'b1;
            MEM_H, MEM_HU: legal = ~st_off[0];
            MEM_W:         legal = (st_off == 2'b00);
            default:       legal = 1'b0;
        endcase
        if (st_store && st_op[2]) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        sext      = ~ld_op[2];
        ld_byte   = rdata[{ld_off, 3'b000} +: 8];
        ld_half   = ld_off[1] ? rdata[31:16] : rdata[15:0];
        rdata_ext = rdata;
        case (ld_op[1:0])
            2'b00:   rdata_ext = {{24{sext & ld_byte[7]}}, ld_byte};
            2'b01:   rdata_ext = {{16{sext & ld_half[15]}}, ld_half};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts a memory instruction from execute, runs one
// request/grant/response transaction on the data port and stalls the core.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_w,
    input  logic              mem_to_reg,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    lsu_if.master             dmem
);

    logic [1:0]        state;
    logic [1:0]        next_state;
    lsu_op_t           op_q;
    logic              accept;
    logic              legal;
    logic [BE_W-1:0]   be_c;
    logic [DATA_W-1:0] wdata_rep;
    logic [DATA_W-1:0] rdata_ext;

    assign accept = (state == LSU_IDLE) && start && (mem_w || mem_to_reg);

    lsu_align u_align (
        .st_op     (mem_op),
        .st_off    (addr[1:0]),
        .st_store  (mem_w),
        .st_wdata  (wdata),
        .be        (be_c),
        .wdata_rep (wdata_rep),
        .legal     (legal),
        .ld_op     (op_q.op),
        .ld_off    (op_q.off),
        .rdata     (dmem.dmem_rdata),
        .rdata_ext (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LSU_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Illegal accesses skip the bus and report straight from IDLE.
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            LSU_IDLE: begin
                if (accept) begin
                    stall      = 1'b1;
                    next_state = legal ? LSU_REQ : LSU_DONE;
                end
            end
            LSU_REQ: begin
                stall = 1'b1;
                if (dmem.dmem_gnt) begin
                    next_state = op_q.store ? LSU_DONE : LSU_RESP;
                end
            end
            LSU_RESP: begin
                stall = 1'b1;
                if (dmem.dmem_rvalid) begin
                    next_state = LSU_DONE;
                end
            end
            LSU_DONE: begin
                next_state = LSU_IDLE;
            end
        endcase
    end

    // Bus fields are loaded on entry to REQ and held until the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q            <= '0;
            done            <= 1'b0;
            err             <= 1'b0;
            load_data       <= '0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
        end else begin
            done <= (next_state == LSU_DONE);
            err  <= accept && !legal;

            if (accept) begin
                op_q.store <= mem_w;
                op_q.op    <= mem_op;
                op_q.off   <= addr[1:0];
                if (legal) begin
                    dmem.dmem_req   <= 1'b1;
                    dmem.dmem_we    <= mem_w;
                    dmem.dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    dmem.dmem_be    <= be_c;
                    dmem.dmem_wdata <= wdata_rep;
                end
            end

            if ((state == LSU_REQ) && dmem.dmem_gnt) begin
                dmem.dmem_req   <= 1'b0;
                dmem.dmem_we    <= 1'b0;
                dmem.dmem_addr  <= '0;
                dmem.dmem_be    <= '0;
                dmem.dmem_wdata <= '0;
            end

            if ((state == LSU_RESP) && dmem.dmem_rvalid) begin
                load_data <= rdata_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, hand-written corner
// sequences and randomized accesses against a word-memory reference model.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    localparam int unsigned ADDR_W  = 32;
    localparam int          MAX_CYC = 60;

    typedef struct {
        bit          w;
        bit          r;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        int          gd;
        int          rd;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          done_cyc;
        bit          err;
        logic [31:0] ld;
        int          txns;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        bit          we;
    } exp_t;

    typedef struct {
        vec_t v;
        exp_t e;
    } rec_t;

    typedef struct {
        int          done_cyc;
        logic        err;
        logic [31:0] ld;
        int          txns;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        bit          stall_ok;
        bit          stable_ok;
        bit          timeout;
        logic        done_prev;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              mem_w;
    logic              mem_to_reg;
    logic [2:0]        mem_op;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              stall;
    logic              done;
    logic              err;
    logic [31:0]       load_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [int unsigned];

    lsu_if #(.ADDR_W(ADDR_W)) dmem ();

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mem_w      (mem_w),
        .mem_to_reg (mem_to_reg),
        .mem_op     (mem_op),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .dmem       (dmem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%08h, expected 0x%08h", tag, what, act, exp);
        end
    endtask

    function automatic rec_t mk(input bit w, input bit r, input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] wd,
                                input int gd, input int rd, input logic [31:0] rdata,
                                input int dc, input bit er, input logic [31:0] ld,
                                input int tx, input logic [3:0] be,
                                input logic [31:0] wde, input logic [31:0] ae);
        rec_t t;
        t.v.w = w;  t.v.r = r;  t.v.op = op;  t.v.addr = a;  t.v.wd = wd;
        t.v.gd = gd;  t.v.rd = rd;  t.v.rdata = rdata;
        t.e.done_cyc = dc;  t.e.err = er;  t.e.ld = ld;  t.e.txns = tx;
        t.e.be = be;  t.e.wdata = wde;  t.e.addr = ae;  t.e.we = w;
        return t;
    endfunction

    // Reference: derive everything from access size, offset and a word memory.
    function automatic exp_t model(input vec_t v, input logic [31:0] ld_prev);
        exp_t        e;
        int unsigned size;
        int unsigned off;
        logic [31:0] word;
        logic [31:0] val;
        logic [31:0] mask;
        bit          bad;
        size = (v.op[1:0] == 2'b00) ? 1 : (v.op[1:0] == 2'b01) ? 2 : 4;
        off  = v.addr % 4;
        bad  = (v.op == 3'b011) || (v.op >= 3'd6) || (v.w && v.op[2]) || ((off % size) != 0);
        e.err = bad;  e.ld = ld_prev;  e.we = v.w;  e.addr = v.addr & ~32'h3;
        e.be = '0;  e.wdata = '0;
        if (bad) begin
            e.done_cyc = 1;
            e.txns     = 0;
        end else begin
            e.txns = 1;
            e.be   = 4'(((32'h1 << size) - 32'h1) << off);
            case (size)
                1:       e.wdata = {24'h0, v.wd[7:0]} * 32'h0101_0101;
                2:       e.wdata = {16'h0, v.wd[15:0]} * 32'h0001_0001;
                default: e.wdata = v.wd;
            endcase
            if (v.w) begin
                e.done_cyc = 2 + v.gd;
            end else begin
                word = mem.exists(e.addr >> 2) ? mem[e.addr >> 2] : v.rdata;
                mask = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
                val  = (word >> (8 * off)) & mask;
                if (!v.op[2] && size != 4 && val[8 * size - 1]) val = val | ~mask;
                e.ld       = val;
                e.done_cyc = 2 + v.gd + v.rd;
            end
        end
        return e;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] word;
        word = mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
        end
        mem[a >> 2] = word;
    endtask

    // One access with a responder that grants after gd request cycles and
    // returns read data rd cycles after the grant; start stays up through done.
    task automatic run_op(input vec_t v, output obs_t o);
        int cyc;
        int nreq;
        int gcyc;
        bit got;
        o.done_cyc = -1;  o.err = 1'b0;  o.ld = '0;  o.txns = 0;  o.be = '0;
        o.wdata = '0;  o.addr = '0;  o.we = 1'b0;
        o.stall_ok = 1'b1;  o.stable_ok = 1'b1;  o.timeout = 1'b0;
        @(negedge clk);
        o.done_prev = done;
        start = 1'b1;  mem_w = v.w;  mem_to_reg = v.r;  mem_op = v.op;
        addr = v.addr;  wdata = v.wd;
        dmem.dmem_gnt = 1'b0;  dmem.dmem_rvalid = 1'b0;  dmem.dmem_rdata = '0;
        #1;
        if (stall !== 1'b1) o.stall_ok = 1'b0;
        cyc = 0;  nreq = 0;  gcyc = -1;  got = 1'b0;
        while (!got && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
            dmem.dmem_gnt = 1'b0;
            dmem.dmem_rvalid = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;  o.done_cyc = cyc;  o.err = err;  o.ld = load_data;
            end
            if (dmem.dmem_req === 1'b1) begin
                nreq++;
                if (nreq == 1) begin
                    o.be = dmem.dmem_be;  o.wdata = dmem.dmem_wdata;
                    o.addr = dmem.dmem_addr;  o.we = dmem.dmem_we;
                end else if (dmem.dmem_be !== o.be || dmem.dmem_wdata !== o.wdata ||
                             dmem.dmem_addr !== o.addr || dmem.dmem_we !== o.we) begin
                    o.stable_ok = 1'b0;
                end
                if (nreq > v.gd) begin
                    dmem.dmem_gnt = 1'b1;
                    o.txns++;
                    gcyc = cyc;
                end
            end else if (!v.w && gcyc >= 0 && cyc == gcyc + v.rd) begin
                dmem.dmem_rvalid = 1'b1;
                dmem.dmem_rdata  = mem.exists(o.addr >> 2) ? mem[o.addr >> 2] : v.rdata;
            end
            #1;
            if (stall !== (got ? 1'b0 : 1'b1)) o.stall_ok = 1'b0;
        end
        o.timeout = !got;
    endtask

    task automatic check_obs(input string tag, input bit is_store, input obs_t o, input exp_t e);
        check(tag, "done_prev", 32'(o.done_prev), 32'h0);
        check(tag, "timeout", 32'(o.timeout), 32'h0);
        check(tag, "done_cycle", o.done_cyc, e.done_cyc);
        check(tag, "err", 32'(o.err), 32'(e.err));
        check(tag, "load_data", o.ld, e.ld);
        check(tag, "transactions", o.txns, e.txns);
        check(tag, "stall", 32'(o.stall_ok), 32'h1);
        if (e.txns != 0) begin
            check(tag, "be", 32'(o.be), 32'(e.be));
            check(tag, "addr", o.addr, e.addr);
            check(tag, "we", 32'(o.we), 32'(e.we));
            check(tag, "stable", 32'(o.stable_ok), 32'h1);
            if (is_store) check(tag, "wdata", o.wdata, e.wdata);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, "done", 32'(done), 32'h0);
        check(tag, "err", 32'(err), 32'h0);
        check(tag, "stall", 32'(stall), 32'h0);
        check(tag, "load_data", load_data, 32'h0);
        check(tag, "dmem_req", 32'(dmem.dmem_req), 32'h0);
        check(tag, "dmem_we", 32'(dmem.dmem_we), 32'h0);
        check(tag, "dmem_addr", dmem.dmem_addr, 32'h0);
        check(tag, "dmem_be", 32'(dmem.dmem_be), 32'h0);
        check(tag, "dmem_wdata", dmem.dmem_wdata, 32'h0);
    endtask

    rec_t        tbl [8];
    vec_t        v;
    exp_t        e;
    obs_t        o;
    logic [31:0] ld_model;
    bit          busy;

    initial begin
        rst_n = 1'b0;  start = 1'b0;  mem_w = 1'b0;  mem_to_reg = 1'b0;
        mem_op = '0;  addr = '0;  wdata = '0;
        dmem.dmem_gnt = 1'b0;  dmem.dmem_rvalid = 1'b0;  dmem.dmem_rdata = '0;

        //                w  r  op      addr          wdata         gd rd rdata        done err load_data     tx be       dmem_wdata    dmem_addr
        tbl[0] = mk(1, 0, MEM_B,  32'h1003, 32'h0000_00A5, 0, 1, 32'h0,         2, 0, 32'h0,         1, 4'b1000, 32'hA5A5_A5A5, 32'h1000);
        tbl[1] = mk(0, 1, MEM_B,  32'h2002, 32'h0,         0, 1, 32'h1280_FF34, 3, 0, 32'hFFFF_FF80, 1, 4'b0100, 32'h0,         32'h2000);
        tbl[2] = mk(0, 1, MEM_BU, 32'h2002, 32'h0,         0, 1, 32'h1280_FF34, 3, 0, 32'h0000_0080, 1, 4'b0100, 32'h0,         32'h2000);
        tbl[3] = mk(0, 1, MEM_H,  32'h2002, 32'h0,         3, 2, 32'h8001_FFFF, 7, 0, 32'hFFFF_8001, 1, 4'b1100, 32'h0,         32'h2000);
        tbl[4] = mk(0, 1, MEM_W,  32'h3001, 32'h0,         0, 1, 32'h0,         1, 1, 32'hFFFF_8001, 0, 4'b0000, 32'h0,         32'h0);
        tbl[5] = mk(0, 1, 3'b011, 32'h3000, 32'h0,         0, 1, 32'h0,         1, 1, 32'hFFFF_8001, 0, 4'b0000, 32'h0,         32'h0);
        tbl[6] = mk(1, 0, MEM_W,  32'h0040, 32'hDEAD_BEEF, 0, 1, 32'h0,         2, 0, 32'hFFFF_8001, 1, 4'b1111, 32'hDEAD_BEEF, 32'h40);
        tbl[7] = mk(0, 1, MEM_W,  32'h0040, 32'h0,         0, 1, 32'h0,         3, 0, 32'hDEAD_BEEF, 1, 4'b1111, 32'h0,         32'h40);

        #2;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].v, o);
            check_obs($sformatf("vec%0d", i), tbl[i].v.w, o, tbl[i].e);
            if (tbl[i].v.w && tbl[i].e.txns != 0) mem_write(tbl[i].e.addr, tbl[i].e.be, tbl[i].e.wdata);
        end

        // start without mem_w/mem_to_reg must be ignored
        @(negedge clk);
        start = 1'b1;  mem_w = 1'b0;  mem_to_reg = 1'b0;  mem_op = MEM_W;  addr = 32'h50;
        #1;
        check("nop", "stall", 32'(stall), 32'h0);
        busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (done !== 1'b0 || stall !== 1'b0 || dmem.dmem_req !== 1'b0) busy = 1'b1;
        end
        check("nop", "activity", 32'(busy), 32'h0);

        // reset while waiting for read data, then a stray rvalid
        @(negedge clk);
        start = 1'b1;  mem_w = 1'b0;  mem_to_reg = 1'b1;  mem_op = MEM_W;  addr = 32'h40;
        @(negedge clk);
        check("rst_mid", "req_before", 32'(dmem.dmem_req), 32'h1);
        dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        check("rst_mid", "in_resp", 32'(dmem.dmem_req | done), 32'h0);
        rst_n = 1'b0;  start = 1'b0;  mem_to_reg = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        dmem.dmem_rvalid = 1'b1;  dmem.dmem_rdata = 32'hCAFE_F00D;
        busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem.dmem_rvalid = 1'b0;
            if (done !== 1'b0 || load_data !== 32'h0) busy = 1'b1;
        end
        check("rst_mid", "late_rvalid", 32'(busy), 32'h0);
        check("rst_mid", "load_data", load_data, 32'h0);

        ld_model = 32'h0;
        for (int i = 0; i < 40; i++) begin
            v.w     = 1'($urandom_range(0, 1));
            v.r     = ~v.w;
            v.op    = 3'($urandom_range(0, 7));
            v.addr  = 32'h100 + 32'($urandom_range(0, 15));
            v.wd    = $urandom;
            v.gd    = int'($urandom_range(0, 3));
            v.rd    = int'($urandom_range(1, 3));
            v.rdata = $urandom;
            e = model(v, ld_model);
            run_op(v, o);
            check_obs($sformatf("rnd%0d", i), v.w, o, e);
            if (v.w && e.txns != 0) mem_write(e.addr, e.be, e.wdata);
            ld_model = e.ld;
        end

        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("final", "done_idle", 32'(done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit that consumes the decoder's memory controls (mem_w, mem_to_reg, mem_op = func3) and the ALU-computed address. It runs a request/grant/response transaction on the data-memory port. It generates byte enables and replicated write data, sign- or zero-extends load data, and stalls the core until the access completes. It sits between the execute stage and the data memory.

Parameters:
ADDR_W, 32, byte address width on the core side and memory side (data width fixed at 32)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  core presents a memory instruction this cycle; held until done
mem_w  in  1  1 = store
mem_to_reg  in  1  1 = load (mem_w and mem_to_reg never both 1)
mem_op  in  3  func3: 000 b, 001 h, 010 w, 100 bu, 101 hu
addr  in  ADDR_W  byte address from ALU
wdata  in  32  rs2 store data
stall  out  1  hold pipeline
done  out  1  one-cycle completion pulse
err  out  1  misaligned or illegal mem_op; valid with done
load_data  out  32  extended load result; valid from done, held until next load done
dmem_req  out  1  memory request
dmem_we  out  1  write enable
dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted this cycle
dmem_rvalid  in  1  read data valid
dmem_rdata  in  32  read word

Behaviour:
- Reset values: state IDLE, all outputs 0, latched op/addr/wdata 0, load_data 0.
- States: IDLE, REQ, RESP, DONE. Encoding is 2 bits.
- IDLE:
  - start && (mem_w || mem_to_reg) and access legal -> latch mem_w, mem_op, addr, wdata; go to REQ.
  - start with an illegal access -> go to DONE with err flag set; no memory request is issued.
  - start with neither mem_w nor mem_to_reg -> ignored.
- REQ:
  - dmem_req=1, with dmem_we/addr/be/wdata driven from latched values and stable until gnt.
  - gnt && store -> DONE.
  - gnt && load -> RESP.
- RESP: dmem_req=0. On rvalid, capture extended data into load_data and go to DONE.
- DONE: done=1 and err=latched flag for one cycle, then IDLE. start is ignored in DONE.
- stall = (state==IDLE && start && (mem_w||mem_to_reg)) || state==REQ || state==RESP. stall is 0 in DONE, so the core advances on the done cycle.
- Latency (gnt in first REQ cycle):
  - store: start at cycle 0, done at cycle 2.
  - load with rvalid one cycle after gnt: done at cycle 3.
  - illegal access: done at cycle 1.
- Legality:
  - illegal mem_op: 011, 110, 111.
  - halfword access (mem_op 001/101, or store 001) with addr[0]=1 is misaligned.
  - word access with addr[1:0]!=0 is misaligned.
  - stores with mem_op 1xx are illegal.
- Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111. The same enables apply to loads.
- Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - mem_op[2]=0 sign-extends; mem_op[2]=1 zero-extends.
- Protocol rules:
  - rvalid is ignored outside RESP; gnt is ignored outside REQ.
  - rvalid never arrives in the same cycle as gnt.
  - Unbounded wait in REQ/RESP is legal.
- Reset mid-operation: asynchronous return to IDLE with all outputs cleared. A late rvalid after reset is ignored, and load_data stays 0.

Decomposition:
- Shared package lsu_pkg:
  - MEM_B/H/W/BU/HU mem_op constants.
  - LSU_IDLE/REQ/RESP/DONE state constants.
  - BE_* patterns.
- One natural sub-module, lsu_align (purely combinational):
  - (mem_op, addr[1:0], wdata) -> be, replicated wdata, legal.
  - (mem_op, addr[1:0], rdata) -> extended load data.
- lsu_ctrl holds the FSM and registers.

Test Plan:
- Store byte: sb, addr=0x1003, wdata=0x000000A5, gnt on first REQ cycle -> dmem_addr=0x1000, be=4'b1000, dmem_wdata=0xA5A5A5A5, we=1, done at cycle 2, stall high cycles 0-1.
- Load byte signed/unsigned: lb, then lbu, addr=0x2002, rdata=0x1280FF34 -> load_data 0xFFFFFF80, then 0x00000080, done at cycle 3.
- Load half with delayed gnt: lh, addr=0x2002, gnt after 3 REQ cycles, rvalid 2 cycles later, rdata=0x8001FFFF -> req/addr/be=4'b1100 stable throughout, load_data=0xFFFF8001, done one cycle after rvalid.
- Misaligned word: lw, addr=0x3001 -> no dmem_req ever, done=1 and err=1 at cycle 1. Illegal mem_op=3'b011 gives the same response.
- Back-to-back: sw addr=0x40, wdata=0xDEADBEEF, start held through DONE, then lw addr=0x40 -> exactly one store transaction, be=4'b1111. The second access starts in the cycle after DONE, returns 0xDEADBEEF, and the DONE cycle never retriggers.
- Reset mid-load: rst_n low while in RESP, then a spurious rvalid after reset release -> all outputs 0, state IDLE, load_data stays 0, no done pulse.
